// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encoding and program-RAM constants.
package cpu_pkg;

    localparam int   RAM_BYTES_DEFAULT = 16;
    localparam logic STROBE_INACTIVE   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BYTE = 3'd1,
        S_LOAD_ADDR = 3'd2,
        S_LOAD_DATA = 3'd3,
        S_WRITE     = 3'd4,
        S_DONE      = 3'd5
    } loader_state_e;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit mod-256 accumulator with synchronous clear and add-enable.
module loader_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 8'h00;
        end else if (en_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Fills program RAM from ui_in bytes via MAR-address / MAR-data / RAM-write strobes.
// Optional running checksum of accepted bytes: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import cpu_pkg::*;
#(
    parameter int RAM_BYTES = RAM_BYTES_DEFAULT,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              programming,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              ready,
    output logic [7:0]        bus_out,
    output logic              bus_drive,
    output logic              n_load_addr,
    output logic              n_load_data,
    output logic              n_load_ram,
    output logic              cpu_hold,
    output logic              done_load,
    output logic [ADDR_W-1:0] load_addr,
    output logic [7:0]        checksum,
    output loader_state_e     state_dbg
);

    // Handshake: a byte transfers on a rising edge where ready and byte_valid are both 1;
    // ready is decoded from state only, so it never depends on byte_valid.
    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic              accept;
    logic              last_addr;

    assign accept    = (state_q == S_WAIT_BYTE) && byte_valid && programming;
    assign last_addr = (addr_q == ADDR_W'(RAM_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && !programming) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (programming) state_d = S_WAIT_BYTE;
                S_WAIT_BYTE: if (byte_valid) state_d = S_LOAD_ADDR;
                S_LOAD_ADDR: state_d = S_LOAD_DATA;
                S_LOAD_DATA: state_d = S_WRITE;
                S_WRITE:     state_d = last_addr ? S_DONE : S_WAIT_BYTE;
                S_DONE:      state_d = S_DONE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready       = 1'b0;
        bus_drive   = 1'b0;
        bus_out     = 8'h00;
        n_load_addr = STROBE_INACTIVE;
        n_load_data = STROBE_INACTIVE;
        n_load_ram  = STROBE_INACTIVE;
        done_load   = 1'b0;
        cpu_hold    = (state_q != S_IDLE);
        case (state_q)
            S_WAIT_BYTE: ready = 1'b1;
            S_LOAD_ADDR: begin
                bus_drive   = 1'b1;
                bus_out     = {{(8 - ADDR_W){1'b0}}, addr_q};
                n_load_addr = ~STROBE_INACTIVE;
            end
            S_LOAD_DATA: begin
                bus_drive   = 1'b1;
                bus_out     = byte_q;
                n_load_data = ~STROBE_INACTIVE;
            end
            S_WRITE:     n_load_ram = ~STROBE_INACTIVE;
            S_DONE:      done_load = 1'b1;
            default:     ;
        endcase
    end

    // Address saturates at the last location; leaving a session always rewinds it.
    always_comb begin
        addr_d = addr_q;
        byte_d = accept ? byte_in : byte_q;
        if (state_q == S_IDLE || !programming) begin
            addr_d = '0;
        end else if (state_q == S_WRITE && !last_addr) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            byte_q <= 8'h00;
        end else begin
            addr_q <= addr_d;
            byte_q <= byte_d;
        end
    end

    assign load_addr = addr_q;
    assign state_dbg = state_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    loader_checksum u_checksum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == S_IDLE),
        .en_i   (accept),
        .data_i (byte_in),
        .sum_o  (checksum)
    );
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed sessions plus randomized bytes and stalls.
module tb_program_loader;
    import cpu_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          programming = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          ready;
    logic [7:0]    bus_out;
    logic          bus_drive;
    logic          n_load_addr;
    logic          n_load_data;
    logic          n_load_ram;
    logic          cpu_hold;
    logic          done_load;
    logic [3:0]    load_addr;
    logic [7:0]    checksum;
    loader_state_e state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;

    // Reference model: expected bus traffic and the RAM image a correct load produces.
    logic [7:0] exp_addr_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_ram[16] = '{default: 8'h00};
    int         model_addr = 0;
    logic [7:0] model_sum = 8'h00;

    // Emulated MAR / RAM fed only by the DUT strobes.
    logic [7:0] ram_img[16] = '{default: 8'h00};
    logic [3:0] mar = 4'h0;
    logic [7:0] mdr = 8'h00;

    always #5 clk = ~clk;

    program_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .programming (programming),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .ready       (ready),
        .bus_out     (bus_out),
        .bus_drive   (bus_drive),
        .n_load_addr (n_load_addr),
        .n_load_data (n_load_data),
        .n_load_ram  (n_load_ram),
        .cpu_hold    (cpu_hold),
        .done_load   (done_load),
        .load_addr   (load_addr),
        .checksum    (checksum),
        .state_dbg   (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_load_addr();
        return (model_addr >= 16) ? 4'd15 : 4'(model_addr);
    endfunction

    function automatic logic [7:0] exp_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        return model_sum;
`else
        return 8'h00;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor / scoreboard.
    always @(posedge clk) begin
        if (rst_n) begin
            if (!n_load_addr) begin
                chk("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) chk("addr_bus", 32'(bus_out), 32'(exp_addr_q.pop_front()));
                mar <= bus_out[3:0];
            end
            if (!n_load_data) begin
                chk("data_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("data_bus", 32'(bus_out), 32'(exp_q.pop_front()));
                mdr <= bus_out;
            end
            if (!n_load_ram) ram_img[mar] <= mdr;
            if (!n_load_addr || !n_load_data || !n_load_ram) strobe_cnt <= strobe_cnt + 1;
        end
    end

    // Invariants checked every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("one_strobe_low",
                32'((int'(!n_load_addr) + int'(!n_load_data) + int'(!n_load_ram)) <= 1), 32'd1);
            chk("bus_drive_state", 32'(bus_drive),
                32'(state_dbg == S_LOAD_ADDR || state_dbg == S_LOAD_DATA));
            if (!bus_drive) chk("bus_idle_zero", 32'(bus_out), 32'd0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        byte_in    = b;
        byte_valid = 1'b1;
        exp_addr_q.push_back(8'(model_addr));
        exp_q.push_back(b);
        exp_ram[model_addr[3:0]] = b;
        model_addr++;
        model_sum += b;
        step();
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic drop_session();
        programming = 1'b0;
        step();
        model_addr = 0;
        model_sum  = 8'h00;
        chk("drop_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("drop_load_addr", 32'(load_addr), 32'd0);
        chk("drop_ready", 32'(ready), 32'd0);
        chk("drop_done", 32'(done_load), 32'd0);
    endtask

    task automatic check_ram();
        for (int i = 0; i < 16; i++) chk($sformatf("ram[%0d]", i), 32'(ram_img[i]), 32'(exp_ram[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_bus_drive"}, 32'(bus_drive), 32'd0);
        chk({tag, "_bus_out"}, 32'(bus_out), 32'd0);
        chk({tag, "_nlma"}, 32'(n_load_addr), 32'd1);
        chk({tag, "_nlmd"}, 32'(n_load_data), 32'd1);
        chk({tag, "_nlr"}, 32'(n_load_ram), 32'd1);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done_load), 32'd0);
        chk({tag, "_load_addr"}, 32'(load_addr), 32'd0);
        chk({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        int         first_acc;
        int         n;
        int         sc;
        logic [7:0] saved;

        // Reset values
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Single byte 0xA5
        programming = 1'b1;
        step();
        chk("start_ready", 32'(ready), 32'd1);
        chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'hA5);
        chk("a5_la_bus", 32'(bus_out), 32'h00);
        chk("a5_la_nlma", 32'(n_load_addr), 32'd0);
        chk("a5_la_drive", 32'(bus_drive), 32'd1);
        step();
        chk("a5_ld_bus", 32'(bus_out), 32'hA5);
        chk("a5_ld_nlmd", 32'(n_load_data), 32'd0);
        step();
        chk("a5_wr_nlr", 32'(n_load_ram), 32'd0);
        chk("a5_wr_drive", 32'(bus_drive), 32'd0);
        step();
        step();
        chk("a5_ready_back", 32'(ready), 32'd1);
        chk("a5_load_addr", 32'(load_addr), 32'(exp_load_addr()));
        chk("a5_checksum", 32'(checksum), 32'(exp_checksum()));
        chk("a5_ram0", 32'(ram_img[0]), 32'hA5);
        drop_session();

        // Reset asserted in the middle of a WRITE cycle
        programming = 1'b1;
        step();
        saved = exp_ram[0];
        send_byte(8'h3C);
        step();
        step();
        chk("rst_mid_write_nlr", 32'(n_load_ram), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_write");
        exp_ram[0] = saved;
        model_addr = 0;
        model_sum  = 8'h00;
        programming = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rst_ram0_kept", 32'(ram_img[0]), 32'(exp_ram[0]));

        // 16 back-to-back bytes 0x00..0x0F
        programming = 1'b1;
        step();
        send_byte(8'h00);
        first_acc = cyc;
        for (int i = 1; i < 16; i++) send_byte(8'(i));
        n = 0;
        while (cyc < first_acc + 62 && n < 100) begin
            step();
            n++;
        end
        chk("full_done_early", 32'(done_load), 32'd0);
        step();
        step();
        chk("full_cycle", 32'(cyc - first_acc), 32'd64);
        chk("full_done", 32'(done_load), 32'd1);
        chk("full_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("full_ready", 32'(ready), 32'd0);
        chk("full_load_addr", 32'(load_addr), 32'(exp_load_addr()));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk("full_checksum", 32'(checksum), 32'h78);
`else
        chk("full_checksum", 32'(checksum), 32'h00);
`endif
        check_ram();
        sc = strobe_cnt;
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
        for (int i = 0; i < 3; i++) step();
        byte_valid = 1'b0;
        chk("done_ignore_strobes", 32'(strobe_cnt), 32'(sc));
        chk("done_hold", 32'(done_load), 32'd1);
        drop_session();

        // Random bytes with random stalls between them
        programming = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            int stall;
            stall = int'($urandom_range(0, 3));
            wait_ready();
            for (int s = 0; s < stall; s++) begin
                sc = strobe_cnt;
                step();
                chk("stall_ready", 32'(ready), 32'd1);
                chk("stall_no_strobe", 32'(strobe_cnt), 32'(sc));
            end
            send_byte(8'($urandom));
        end
        n = 0;
        while (done_load !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("rand_done", 32'(done_load), 32'd1);
        chk("rand_checksum", 32'(checksum), 32'(exp_checksum()));
        check_ram();
        drop_session();

        // Session dropped after five bytes, then restarted at address 0
        programming = 1'b1;
        step();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        wait_ready();
        chk("part_load_addr", 32'(load_addr), 32'(exp_load_addr()));
        drop_session();
        programming = 1'b1;
        step();
        send_byte(8'h11);
        wait_ready();
        chk("restart_load_addr", 32'(load_addr), 32'(exp_load_addr()));
        chk("restart_ram0", 32'(ram_img[0]), 32'h11);
        chk("restart_checksum", 32'(checksum), 32'(exp_checksum()));
        check_ram();
        drop_session();
        chk("queues_drained", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
